// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: 2-bit BHT counter encodings,
// the counter reset value, the sequential PC increment and the saturating
// counter update used by the branch history table.
package branch_resolve_unit_pkg;

    // 2-bit branch history counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;   // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;   // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;   // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;   // strongly taken

    localparam logic [1:0]  BHT_RESET_VAL = CTR_WNT;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Saturating move of a counter toward taken (up) or not-taken (down).
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        if (taken) begin
            result = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            result = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_counter_array.sv
// Branch history table: register array of 2-bit saturating counters.
// Ports: clk/rst (async, active-high, resets every entry to weakly not-taken),
//        rd_idx/rd_ctr (combinational read), wr_en/wr_idx/wr_taken (saturating update).
// A read of the index being written in the same cycle returns the pre-update value.
module bht_counter_array
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    // Read straight from the flops: no write-to-read bypass.
    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_RESET_VAL;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolution: compares the actual outcome of branches/jumps with
// the fetch-time prediction, issues a registered redirect plus a multi-cycle flush
// on mispredict, keeps saturating statistics and owns the BHT that predicts if_pc.
// Ports: clk/rst; if_pc -> pred_taken; ex_mem_* resolve inputs; flush, redirect_valid,
//        redirect_pc; stat_branches, stat_mispredicts. Outcome latency is 1 cycle.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W        = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    input  logic [31:0]       ex_mem_pc,
    input  logic              ex_mem_branch,
    input  logic              ex_mem_branch2,
    input  logic              ex_mem_jump,
    input  logic              zero_flag_ex_mem,
    input  logic              ex_mem_br_taken,
    input  logic [31:0]       ex_mem_next_address_branch,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

    logic       resolve;
    logic       actual;
    logic       mispred;
    logic [1:0] rd_ctr;

    // Only the BHT index bits of the fetch PC matter for prediction.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Flush is high exactly while the down-counter is non-zero, so an async
    // reset of the counter drops flush immediately.
    assign flush = (flush_cnt_q != 3'd0);

    // While flushing, the instruction in MEM is being squashed: ignore it.
    assign resolve = (ex_mem_branch | ex_mem_branch2 | ex_mem_jump) & ~flush;
    assign actual  = ex_mem_jump
                   | (ex_mem_branch  &  zero_flag_ex_mem)
                   | (ex_mem_branch2 & ~zero_flag_ex_mem);
    assign mispred = resolve & (actual != ex_mem_br_taken);

    bht_counter_array #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (resolve),
        .wr_idx   (ex_mem_pc[IDX_W+1:2]),
        .wr_taken (actual)
    );

    assign pred_taken = rd_ctr[1];

    always_comb begin
        flush_cnt_d        = flush_cnt_q;
        redirect_valid_d   = mispred;
        redirect_pc_d      = redirect_pc_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;

        if (mispred) begin
            flush_cnt_d   = FLUSH_INIT;
            redirect_pc_d = actual ? ex_mem_next_address_branch : ex_mem_pc + PC_INC;
        end else if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end

        if (resolve && (stat_branches_q != {STAT_W{1'b1}})) begin
            stat_branches_d = stat_branches_q + STAT_W'(1);
        end
        if (mispred && (stat_mispredicts_q != {STAT_W{1'b1}})) begin
            stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q        <= 3'd0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 32'd0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            flush_cnt_q        <= flush_cnt_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, a reset-during-flush
// sequence, then randomized traffic against a behavioural model. A second
// instance with 4-bit statistics exercises counter saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] ex_mem_pc = 32'd0;
    logic        ex_mem_branch = 1'b0;
    logic        ex_mem_branch2 = 1'b0;
    logic        ex_mem_jump = 1'b0;
    logic        zero_flag_ex_mem = 1'b0;
    logic        ex_mem_br_taken = 1'b0;
    logic [31:0] ex_mem_next_address_branch = 32'd0;

    logic        pred_taken, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    logic        s_pred_taken, s_flush, s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_stat_branches, s_stat_mispredicts;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.IDX_W(6), .FLUSH_CYCLES(2), .STAT_W(16)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .if_pc                      (if_pc),
        .pred_taken                 (pred_taken),
        .ex_mem_pc                  (ex_mem_pc),
        .ex_mem_branch              (ex_mem_branch),
        .ex_mem_branch2             (ex_mem_branch2),
        .ex_mem_jump                (ex_mem_jump),
        .zero_flag_ex_mem           (zero_flag_ex_mem),
        .ex_mem_br_taken            (ex_mem_br_taken),
        .ex_mem_next_address_branch (ex_mem_next_address_branch),
        .flush                      (flush),
        .redirect_valid             (redirect_valid),
        .redirect_pc                (redirect_pc),
        .stat_branches              (stat_branches),
        .stat_mispredicts           (stat_mispredicts)
    );

    branch_resolve_unit #(.IDX_W(6), .FLUSH_CYCLES(2), .STAT_W(4)) dut_small (
        .clk                        (clk),
        .rst                        (rst),
        .if_pc                      (if_pc),
        .pred_taken                 (s_pred_taken),
        .ex_mem_pc                  (ex_mem_pc),
        .ex_mem_branch              (ex_mem_branch),
        .ex_mem_branch2             (ex_mem_branch2),
        .ex_mem_jump                (ex_mem_jump),
        .zero_flag_ex_mem           (zero_flag_ex_mem),
        .ex_mem_br_taken            (ex_mem_br_taken),
        .ex_mem_next_address_branch (ex_mem_next_address_branch),
        .flush                      (s_flush),
        .redirect_valid             (s_redirect_valid),
        .redirect_pc                (s_redirect_pc),
        .stat_branches              (s_stat_branches),
        .stat_mispredicts           (s_stat_mispredicts)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] ipc, input logic [31:0] pc, input logic b,
                         input logic b2, input logic j, input logic z, input logic bt,
                         input logic [31:0] tgt);
        if_pc                      = ipc;
        ex_mem_pc                  = pc;
        ex_mem_branch              = b;
        ex_mem_branch2             = b2;
        ex_mem_jump                = j;
        zero_flag_ex_mem           = z;
        ex_mem_br_taken            = bt;
        ex_mem_next_address_branch = tgt;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] if_pc;
        logic [31:0] pc;
        logic        b, b2, j, z, bt;
        logic [31:0] tgt;
        logic        exp_pred;     // pred_taken before the edge
        logic        exp_rv;       // after the edge
        logic [31:0] exp_rpc;
        logic        exp_flush;
        int          exp_br;
        int          exp_mis;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [31:0] ipc, input logic [31:0] pc, input logic b,
                                input logic b2, input logic j, input logic z, input logic bt,
                                input logic [31:0] tgt, input logic ep, input logic erv,
                                input logic [31:0] erpc, input logic efl, input int ebr,
                                input int emis);
        vec_t v;
        v.if_pc = ipc; v.pc = pc; v.b = b; v.b2 = b2; v.j = j; v.z = z; v.bt = bt;
        v.tgt = tgt; v.exp_pred = ep; v.exp_rv = erv; v.exp_rpc = erpc;
        v.exp_flush = efl; v.exp_br = ebr; v.exp_mis = emis;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    int m_bht[64];
    int m_flush_left;
    int m_br, m_mis;
    logic m_rv;
    logic [31:0] m_rpc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_flush_left = 0; m_br = 0; m_mis = 0; m_rv = 1'b0; m_rpc = 32'd0;
    endtask

    task automatic model_step();
        bit is_cti, res, act, mis;
        int k;
        is_cti = ex_mem_branch || ex_mem_branch2 || ex_mem_jump;
        res    = is_cti && (m_flush_left == 0);
        act    = ex_mem_jump || (ex_mem_branch && zero_flag_ex_mem)
                 || (ex_mem_branch2 && !zero_flag_ex_mem);
        mis    = res && (act != ex_mem_br_taken);
        if (res) begin
            k = idx_of(ex_mem_pc);
            if (act) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
            else     m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
            if (m_br < 65535) m_br++;
            if (mis && m_mis < 65535) m_mis++;
        end
        m_rv = mis;
        if (mis) begin
            m_rpc = act ? ex_mem_next_address_branch : ex_mem_pc + 32'd4;
            m_flush_left = 2;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
    endtask

    initial begin
        vecs[0]  = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   0, 0, 32'h0,   0, 0, 0);
        vecs[1]  = mk(32'h40, 32'h40, 1,0,0,1,0, 32'h80,  0, 1, 32'h80,  1, 1, 1);
        vecs[2]  = mk(32'h140,32'h0,  0,0,0,0,0, 32'h0,   1, 0, 32'h80,  1, 1, 1);
        vecs[3]  = mk(32'h140,32'h40, 0,1,0,1,1, 32'h80,  1, 0, 32'h80,  0, 1, 1);
        vecs[4]  = mk(32'h40, 32'h40, 0,1,0,1,1, 32'h80,  1, 1, 32'h44,  1, 2, 2);
        vecs[5]  = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   0, 0, 32'h44,  1, 2, 2);
        vecs[6]  = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   0, 0, 32'h44,  0, 2, 2);
        vecs[7]  = mk(32'h40, 32'h40, 1,0,0,1,1, 32'h80,  0, 0, 32'h44,  0, 3, 2);
        vecs[8]  = mk(32'h40, 32'h140,1,0,0,1,1, 32'h80,  1, 0, 32'h44,  0, 4, 2);
        vecs[9]  = mk(32'h40, 32'h40, 0,0,1,0,1, 32'h80,  1, 0, 32'h44,  0, 5, 2);
        vecs[10] = mk(32'h44, 32'h100,0,0,1,0,0, 32'h200, 0, 1, 32'h200, 1, 6, 3);
        vecs[11] = mk(32'h44, 32'h0,  0,0,0,0,0, 32'h0,   0, 0, 32'h200, 1, 6, 3);
        vecs[12] = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   1, 0, 32'h200, 0, 6, 3);
        vecs[13] = mk(32'h40, 32'hFFFF_FFFC,1,0,0,0,1, 32'h80, 1, 1, 32'h0, 1, 7, 4);
        vecs[14] = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   1, 0, 32'h0,   1, 7, 4);
        vecs[15] = mk(32'h40, 32'h0,  0,0,0,0,0, 32'h0,   1, 0, 32'h0,   0, 7, 4);

        // Reset state
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_pred", {31'd0, pred_taken}, 0);
        chk("reset_flush", {31'd0, flush}, 0);
        chk("reset_rv", {31'd0, redirect_valid}, 0);
        chk("reset_rpc", redirect_pc, 0);
        chk("reset_br", {16'd0, stat_branches}, 0);
        chk("reset_mis", {16'd0, stat_mispredicts}, 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].if_pc, vecs[i].pc, vecs[i].b, vecs[i].b2, vecs[i].j,
                  vecs[i].z, vecs[i].bt, vecs[i].tgt);
            #1;
            chk($sformatf("vec%0d_pred", i), {31'd0, pred_taken}, {31'd0, vecs[i].exp_pred});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rv", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_rv});
            chk($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
            chk($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            chk($sformatf("vec%0d_br", i), {16'd0, stat_branches}, vecs[i].exp_br);
            chk($sformatf("vec%0d_mis", i), {16'd0, stat_mispredicts}, vecs[i].exp_mis);
        end

        // Reset asserted in the middle of a flush
        @(negedge clk);
        drive(32'h40, 32'h80, 1, 0, 0, 0, 1, 32'h300);
        @(posedge clk);
        #1;
        chk("midrst_flush_before", {31'd0, flush}, 1);
        chk("midrst_rpc_before", redirect_pc, 32'h84);
        chk("midrst_br_before", {16'd0, stat_branches}, 8);
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_pred_before", {31'd0, pred_taken}, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_flush", {31'd0, flush}, 0);
        chk("midrst_rv", {31'd0, redirect_valid}, 0);
        chk("midrst_rpc", redirect_pc, 0);
        chk("midrst_br", {16'd0, stat_branches}, 0);
        chk("midrst_mis", {16'd0, stat_mispredicts}, 0);
        chk("midrst_pred", {31'd0, pred_taken}, 0);
        chk("midrst_small_br", {28'd0, s_stat_branches}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] ipc, pc;
            @(negedge clk);
            ipc = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            pc  = ($urandom_range(0, 15) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                : {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            drive(ipc, pc, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom()), 1'($urandom()), $urandom());
            #1;
            chk("rnd_pred", {31'd0, pred_taken}, {31'd0, m_bht[idx_of(ipc)] >= 2});
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_rv", {31'd0, redirect_valid}, {31'd0, m_rv});
            chk("rnd_rpc", redirect_pc, m_rpc);
            chk("rnd_flush", {31'd0, flush}, {31'd0, m_flush_left > 0});
            chk("rnd_br", {16'd0, stat_branches}, m_br);
            chk("rnd_mis", {16'd0, stat_mispredicts}, m_mis);
            chk("rnd_small_br", {28'd0, s_stat_branches}, (m_br > 15) ? 15 : m_br);
            chk("rnd_small_mis", {28'd0, s_stat_mispredicts}, (m_mis > 15) ? 15 : m_mis);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
